id_ex_stage: RTL and testbench

ID/EX pipeline register of the 5-stage RV32I pipeline, directly downstream of the decode stage. It captures the decoded control bundle, operands and immediate every cycle. It detects load-use hazards and inserts a bubble while stalling upstream, and squashes on taken branch. It registers per-operand forwarding selects for EX and bypasses same-edge write-back data into the captured operands.

---
 rtl/rv_pipe_pkg.sv | 42 ++++
 rtl/id_ex_fwd_unit.sv | 50 +++++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types and codes for the RV32I pipeline registers.
// Holds write-back/forward select encodings, the ID/EX bundles and a register-match helper.
package rv_pipe_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       a_sel;
    logic       b_sel;
    logic       reg_wren;
    logic       brun;
    logic       mem_wren;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    logic [2:0] funct_3;
  } id_ex_ctrl_t;

  // All-zero value of this struct is both the reset state and the bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    id_ex_ctrl_t ctrl;
  } id_ex_reg_t;

  // True when a producer writing rd supplies source register rs; x0 never matches.
  function automatic logic rd_hit(input logic wren, input logic [4:0] rd, input logic [4:0] rs);
    return wren && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_fwd_unit.sv
// Hazard and forwarding compares for the ID/EX register.
// Produces the load-use flag, next-cycle EX forward selects and write-back bypass enables.
module id_ex_fwd_unit
  import rv_pipe_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_hazard_on,
  input  logic       rs2_hazard_on,
  input  logic       ex_valid,
  input  logic       ex_reg_wren,
  input  logic [1:0] ex_wb_sel,
  input  logic [4:0] ex_rd,
  input  logic       exmem_reg_wren,
  input  logic [4:0] exmem_rd,
  input  logic       wb_reg_wren,
  input  logic [4:0] wb_rd,
  output logic       load_use,
  output logic [1:0] fwd_a_nxt,
  output logic [1:0] fwd_b_nxt,
  output logic       byp_a,
  output logic       byp_b
);

  logic ex_is_load;
  logic ex_writes;

  assign ex_is_load = ex_valid && (ex_wb_sel == WB_MEM);
  assign ex_writes  = ex_valid && ex_reg_wren;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    fwd_a_nxt = FWD_REG;
    fwd_b_nxt = FWD_REG;

    // The instruction in EX now sits in MEM next cycle, the one in MEM sits in WB.
    if (rd_hit(ex_writes, ex_rd, rs1))                fwd_a_nxt = FWD_MEM;
    else if (rd_hit(exmem_reg_wren, exmem_rd, rs1))   fwd_a_nxt = FWD_WB;

    if (rd_hit(ex_writes, ex_rd, rs2))                fwd_b_nxt = FWD_MEM;
    else if (rd_hit(exmem_reg_wren, exmem_rd, rs2))   fwd_b_nxt = FWD_WB;
  end

  assign load_use = (rs1_hazard_on && rd_hit(ex_is_load, ex_rd, rs1)) ||
                    (rs2_hazard_on && rd_hit(ex_is_load, ex_rd, rs2));

  assign byp_a = rd_hit(wb_reg_wren, wb_rd, rs1);
  assign byp_b = rd_hit(wb_reg_wren, wb_rd, rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded bundle, inserts load-use bubbles,
// squashes on taken branch, and registers EX forward selects with write-back bypass.
module id_ex_stage
  import rv_pipe_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_a_sel,
  input  logic        i_b_sel,
  input  logic        i_reg_wren,
  input  logic        i_brun,
  input  logic        i_mem_wren,
  input  logic [3:0]  i_alu_sel,
  input  logic [1:0]  i_wb_sel,
  input  logic [2:0]  i_funct_3,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm,
  input  logic        i_rs1_hazard_on,
  input  logic        i_rs2_hazard_on,
  input  logic [4:0]  i_exmem_rd,
  input  logic        i_exmem_reg_wren,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_reg_wren,
  input  logic [31:0] i_wb_rd_data,
  input  logic        i_flush,
  input  logic        i_hold,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd,
  output logic [3:0]  o_alu_sel,
  output logic [1:0]  o_wb_sel,
  output logic [2:0]  o_funct_3,
  output logic        o_a_sel,
  output logic        o_b_sel,
  output logic        o_reg_wren,
  output logic        o_brun,
  output logic        o_mem_wren,
  output logic [1:0]  o_fwd_a_sel,
  output logic [1:0]  o_fwd_b_sel,
  output logic        o_stall
);

  logic [4:0] rs1, rs2, rd;
  logic       unused_inst_bits;
  logic       load_use;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;
  logic       byp_a, byp_b;

  id_ex_reg_t stage_d, stage_q;

  assign rs1 = i_inst[19:15];
  assign rs2 = i_inst[24:20];
  assign rd  = i_inst[11:7];
  assign unused_inst_bits = ^{i_inst[31:25], i_inst[14:12], i_inst[6:0]};

  id_ex_fwd_unit u_fwd (
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_hazard_on  (i_rs1_hazard_on),
    .rs2_hazard_on  (i_rs2_hazard_on),
    .ex_valid       (stage_q.valid),
    .ex_reg_wren    (stage_q.ctrl.reg_wren),
    .ex_wb_sel      (stage_q.ctrl.wb_sel),
    .ex_rd          (stage_q.rd),
    .exmem_reg_wren (i_exmem_reg_wren),
    .exmem_rd       (i_exmem_rd),
    .wb_reg_wren    (i_wb_reg_wren),
    .wb_rd          (i_wb_rd),
    .load_use       (load_use),
    .fwd_a_nxt      (fwd_a_nxt),
    .fwd_b_nxt      (fwd_b_nxt),
    .byp_a          (byp_a),
    .byp_b          (byp_b)
  );

  always_comb begin
    stage_d               = '0;
    stage_d.valid         = 1'b1;
    stage_d.pc            = i_pc;
    stage_d.rs1_data      = byp_a ? i_wb_rd_data : i_rs1_data;
    stage_d.rs2_data      = byp_b ? i_wb_rd_data : i_rs2_data;
    stage_d.imm           = i_imm;
    stage_d.rd            = rd;
    stage_d.fwd_a         = fwd_a_nxt;
    stage_d.fwd_b         = fwd_b_nxt;
    stage_d.ctrl.a_sel    = i_a_sel;
    stage_d.ctrl.b_sel    = i_b_sel;
    stage_d.ctrl.reg_wren = i_reg_wren;
    stage_d.ctrl.brun     = i_brun;
    stage_d.ctrl.mem_wren = i_mem_wren;
    stage_d.ctrl.alu_sel  = i_alu_sel;
    stage_d.ctrl.wb_sel   = i_wb_sel;
    stage_d.ctrl.funct_3  = i_funct_3;
  end

  // Hold masks everything; flush outranks the load-use stall.
  assign o_stall = load_use && !i_hold && !i_flush;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_reset_n) begin
      // NOTE: the whole bundle is reset; these are control-bearing flops, not a memory array.
      stage_q <= '0;
    end else if (!i_hold) begin
      if (i_flush || load_use) stage_q <= '0;
      else                     stage_q <= stage_d;
    end
  end

  assign o_valid     = stage_q.valid;
  assign o_pc        = stage_q.pc;
  assign o_rs1_data  = stage_q.rs1_data;
  assign o_rs2_data  = stage_q.rs2_data;
  assign o_imm       = stage_q.imm;
  assign o_rd        = stage_q.rd;
  assign o_alu_sel   = stage_q.ctrl.alu_sel;
  assign o_wb_sel    = stage_q.ctrl.wb_sel;
  assign o_funct_3   = stage_q.ctrl.funct_3;
  assign o_a_sel     = stage_q.ctrl.a_sel;
  assign o_b_sel     = stage_q.ctrl.b_sel;
  assign o_reg_wren  = stage_q.ctrl.reg_wren;
  assign o_brun      = stage_q.ctrl.brun;
  assign o_mem_wren  = stage_q.ctrl.mem_wren;
  assign o_fwd_a_sel = stage_q.fwd_a;
  assign o_fwd_b_sel = stage_q.fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, load-use stall,
// MEM/WB forwarding, write-back bypass, flush and hold priority.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_inst, i_pc;
  logic        i_a_sel, i_b_sel, i_reg_wren, i_brun, i_mem_wren;
  logic [3:0]  i_alu_sel;
  logic [1:0]  i_wb_sel;
  logic [2:0]  i_funct_3;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm;
  logic        i_rs1_hazard_on, i_rs2_hazard_on;
  logic [4:0]  i_exmem_rd;
  logic        i_exmem_reg_wren;
  logic [4:0]  i_wb_rd;
  logic        i_wb_reg_wren;
  logic [31:0] i_wb_rd_data;
  logic        i_flush, i_hold;

  logic        o_valid;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rd;
  logic [3:0]  o_alu_sel;
  logic [1:0]  o_wb_sel;
  logic [2:0]  o_funct_3;
  logic        o_a_sel, o_b_sel, o_reg_wren, o_brun, o_mem_wren;
  logic [1:0]  o_fwd_a_sel, o_fwd_b_sel;
  logic        o_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  id_ex_stage dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inst(i_inst), .i_pc(i_pc),
    .i_a_sel(i_a_sel), .i_b_sel(i_b_sel), .i_reg_wren(i_reg_wren), .i_brun(i_brun),
    .i_mem_wren(i_mem_wren), .i_alu_sel(i_alu_sel), .i_wb_sel(i_wb_sel), .i_funct_3(i_funct_3),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_rs1_hazard_on(i_rs1_hazard_on), .i_rs2_hazard_on(i_rs2_hazard_on),
    .i_exmem_rd(i_exmem_rd), .i_exmem_reg_wren(i_exmem_reg_wren),
    .i_wb_rd(i_wb_rd), .i_wb_reg_wren(i_wb_reg_wren), .i_wb_rd_data(i_wb_rd_data),
    .i_flush(i_flush), .i_hold(i_hold),
    .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_imm(o_imm), .o_rd(o_rd), .o_alu_sel(o_alu_sel), .o_wb_sel(o_wb_sel),
    .o_funct_3(o_funct_3), .o_a_sel(o_a_sel), .o_b_sel(o_b_sel), .o_reg_wren(o_reg_wren),
    .o_brun(o_brun), .o_mem_wren(o_mem_wren), .o_fwd_a_sel(o_fwd_a_sel),
    .o_fwd_b_sel(o_fwd_b_sel), .o_stall(o_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] wb_sel, input logic reg_wren,
                       input logic h1, input logic h2, input logic [31:0] pc);
    i_inst          = {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    i_wb_sel        = wb_sel;
    i_reg_wren      = reg_wren;
    i_rs1_hazard_on = h1;
    i_rs2_hazard_on = h2;
    i_pc            = pc;
  endtask

  task automatic clear_side();
    i_exmem_rd = 5'd0; i_exmem_reg_wren = 1'b0;
    i_wb_rd = 5'd0; i_wb_reg_wren = 1'b0; i_wb_rd_data = 32'd0;
    i_flush = 1'b0; i_hold = 1'b0;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_inst = '0; i_pc = '0; i_a_sel = 0; i_b_sel = 0; i_reg_wren = 0; i_brun = 0;
    i_mem_wren = 0; i_alu_sel = '0; i_wb_sel = '0; i_funct_3 = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
    i_rs1_hazard_on = 0; i_rs2_hazard_on = 0;
    clear_side();

    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc",    o_pc,         32'd0);
    check("rst_fwd_a", 32'(o_fwd_a_sel), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    @(negedge i_clk) i_reset_n = 1'b1;

    // lw x5, 4(x1)
    drive(5'd5, 5'd1, 5'd0, WB_MEM, 1'b1, 1'b1, 1'b0, 32'h100);
    i_imm = 32'd4;
    step();
    check("lw_valid",  32'(o_valid),  32'd1);
    check("lw_rd",     32'(o_rd),     32'd5);
    check("lw_pc",     o_pc,          32'h100);
    check("lw_wb_sel", 32'(o_wb_sel), 32'd1);
    check("lw_imm",    o_imm,         32'd4);

    // add x6, x5, x1 right behind the load
    drive(5'd6, 5'd5, 5'd1, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h104);
    i_imm = 32'd0;
    #1 check("lu_stall", 32'(o_stall), 32'd1);
    step();
    check("lu_bubble_valid", 32'(o_valid),    32'd0);
    check("lu_bubble_wren",  32'(o_reg_wren), 32'd0);
    check("lu_bubble_pc",    o_pc,            32'd0);
    i_exmem_rd = 5'd5; i_exmem_reg_wren = 1'b1;
    #1 check("lu_release_stall", 32'(o_stall), 32'd0);
    step();
    check("lu_add_valid", 32'(o_valid),     32'd1);
    check("lu_add_rd",    32'(o_rd),        32'd6);
    check("lu_add_fwd_a", 32'(o_fwd_a_sel), 32'(FWD_WB));
    check("lu_add_fwd_b", 32'(o_fwd_b_sel), 32'(FWD_REG));
    clear_side();

    // add x5, x1, x2 then sub x7, x5, x5
    drive(5'd5, 5'd1, 5'd2, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h108);
    step();
    check("add5_fwd_a", 32'(o_fwd_a_sel), 32'(FWD_REG));
    drive(5'd7, 5'd5, 5'd5, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h10c);
    #1 check("sub_stall", 32'(o_stall), 32'd0);
    step();
    check("sub_fwd_a", 32'(o_fwd_a_sel), 32'(FWD_MEM));
    check("sub_fwd_b", 32'(o_fwd_b_sel), 32'(FWD_MEM));

    // add x0, x1, x2 then sub x7, x0, x0 with x0 on every producer port
    drive(5'd0, 5'd1, 5'd2, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h110);
    step();
    check("add0_rd", 32'(o_rd), 32'd0);
    drive(5'd7, 5'd0, 5'd0, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h114);
    i_exmem_rd = 5'd0; i_exmem_reg_wren = 1'b1;
    i_wb_rd = 5'd0; i_wb_reg_wren = 1'b1; i_wb_rd_data = 32'hDEADBEEF;
    i_rs1_data = 32'h0000_1234;
    step();
    check("x0_fwd_a",    32'(o_fwd_a_sel), 32'(FWD_REG));
    check("x0_fwd_b",    32'(o_fwd_b_sel), 32'(FWD_REG));
    check("x0_no_bypass", o_rs1_data,      32'h0000_1234);
    clear_side();

    // or x4, x3, x2 with write-back of x3 on the capture edge
    drive(5'd4, 5'd3, 5'd2, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h118);
    i_rs1_data = 32'h1111_1111; i_rs2_data = 32'h2222_2222;
    i_wb_rd = 5'd3; i_wb_reg_wren = 1'b1; i_wb_rd_data = 32'hDEADBEEF;
    step();
    check("byp_rs1", o_rs1_data, 32'hDEADBEEF);
    check("byp_rs2", o_rs2_data, 32'h2222_2222);
    check("byp_fwd_a", 32'(o_fwd_a_sel), 32'(FWD_REG));
    clear_side();

    // flush wins over a pending load-use
    drive(5'd5, 5'd1, 5'd0, WB_MEM, 1'b1, 1'b1, 1'b0, 32'h200);
    step();
    drive(5'd6, 5'd5, 5'd1, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h204);
    i_flush = 1'b1;
    #1 check("flush_stall", 32'(o_stall), 32'd0);
    step();
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_rd",    32'(o_rd),    32'd0);
    i_flush = 1'b0;

    // hold outranks flush
    drive(5'd9, 5'd1, 5'd2, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h300);
    step();
    drive(5'd10, 5'd1, 5'd2, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h304);
    i_hold = 1'b1; i_flush = 1'b1;
    step();
    check("hold_valid", 32'(o_valid), 32'd1);
    check("hold_pc",    o_pc,         32'h300);
    check("hold_rd",    32'(o_rd),    32'd9);
    i_hold = 1'b0; i_flush = 1'b0;

    // hold masks load-use; stall re-evaluates after release
    drive(5'd5, 5'd1, 5'd0, WB_MEM, 1'b1, 1'b1, 1'b0, 32'h400);
    step();
    drive(5'd6, 5'd5, 5'd1, WB_ALU, 1'b1, 1'b1, 1'b1, 32'h404);
    i_hold = 1'b1;
    #1 check("hold_lu_stall", 32'(o_stall), 32'd0);
    step();
    check("hold_lu_pc", o_pc, 32'h400);
    i_hold = 1'b0;
    #1 check("hold_rel_stall", 32'(o_stall), 32'd1);

    // asynchronous reset in the middle of that stall
    i_reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_stall", 32'(o_stall), 32'd0);
    check("arst_pc",    o_pc,         32'd0);
    check("arst_rd",    32'(o_rd),    32'd0);
    #1 i_reset_n = 1'b1;
    step();
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_rd",    32'(o_rd),    32'd6);
    check("post_rst_pc",    o_pc,         32'h404);
    check("post_rst_fwd_a", 32'(o_fwd_a_sel), 32'(FWD_REG));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
